// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch sequencer: state encoding and
// the program base-address table.
package fetch_pkg;

  localparam int PC_W_DEFAULT = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } fetch_state_t;

  // Unused select code 3 falls back to program 0.
  function automatic logic [31:0] prog_base(input logic [1:0] prog_sel,
                                             input logic [31:0] base0,
                                             input logic [31:0] base1,
                                             input logic [31:0] base2);
    case (prog_sel)
      2'd1:    return base1;
      2'd2:    return base2;
      default: return base0;
    endcase
  endfunction

endpackage

// File: rtl/fetch_sequencer_pc_next.sv
// Next-PC adder: sequential pc+1 or taken jump/branch pc+1+offset, modulo 2^PC_W.
module pc_next_unit
  import fetch_pkg::*;
#(
  parameter int PC_W = PC_W_DEFAULT
) (
  input  logic                   [PC_W-1:0] pc,
  input  logic signed            [PC_W-1:0] offset,
  input  logic                              sel_pc_next,
  input  logic                              cond_true,
  output logic                   [PC_W-1:0] pc_next
);

  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_tgt;

  assign pc_inc  = pc + {{(PC_W-1){1'b0}}, 1'b1};
  // Two's-complement add wraps naturally; negative offsets go below zero silently.
  assign pc_tgt  = pc_inc + $unsigned(offset);
  assign pc_next = (sel_pc_next && cond_true) ? pc_tgt : pc_inc;

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter owner and run/stop handshake between the request interface
// and the instruction decoder.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int          PC_W       = PC_W_DEFAULT,
  parameter int          CYC_W      = 16,
  parameter logic [31:0] PROG0_BASE = 32'd0,
  parameter logic [31:0] PROG1_BASE = 32'd128,
  parameter logic [31:0] PROG2_BASE = 32'd256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req,
  input  logic        [1:0]        prog_sel,
  output logic                     start,
  input  logic                     done_in,
  input  logic                     wpc_en,
  input  logic                     sel_pc_next,
  input  logic                     cond_true,
  input  logic signed [PC_W-1:0]   offset,
  output logic        [PC_W-1:0]   pc,
  output logic                     busy,
  output logic                     ack,
  output logic        [CYC_W-1:0]  cycle_count
);

  fetch_state_t    state;
  logic [PC_W-1:0] base_q;
  logic [PC_W-1:0] pc_next;

  function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
    return (&v) ? v : v + {{(CYC_W-1){1'b0}}, 1'b1};
  endfunction

  // The decoder is held in start everywhere except while a program is running.
  assign start = (state != RUN);

  pc_next_unit #(
    .PC_W(PC_W)
  ) u_pc_next (
    .pc          (pc),
    .offset      (offset),
    .sel_pc_next (sel_pc_next),
    .cond_true   (cond_true),
    .pc_next     (pc_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      base_q      <= '0;
      busy        <= 1'b0;
      ack         <= 1'b0;
      cycle_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack <= 1'b0;
          if (req) begin
            base_q <= PC_W'(prog_base(prog_sel, PROG0_BASE, PROG1_BASE, PROG2_BASE));
            busy   <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          pc          <= base_q;
          cycle_count <= '0;
          busy        <= 1'b1;
          state       <= RUN;
        end
        RUN: begin
          cycle_count <= sat_inc(cycle_count);
          // Terminate wins over any jump fetched in the same cycle; pc holds.
          if (done_in) begin
            busy  <= 1'b0;
            ack   <= 1'b1;
            state <= DONE;
          end else if (wpc_en) begin
            pc <= pc_next;
          end
        end
        DONE: begin
          ack   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer.
module tb_fetch_sequencer;

  localparam int PC_W  = 10;
  localparam int CYC_W = 16;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   req;
  logic [1:0]             prog_sel;
  logic                   start;
  logic                   done_in;
  logic                   wpc_en;
  logic                   sel_pc_next;
  logic                   cond_true;
  logic signed [PC_W-1:0] offset;
  logic [PC_W-1:0]        pc;
  logic                   busy;
  logic                   ack;
  logic [CYC_W-1:0]       cycle_count;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .prog_sel    (prog_sel),
    .start       (start),
    .done_in     (done_in),
    .wpc_en      (wpc_en),
    .sel_pc_next (sel_pc_next),
    .cond_true   (cond_true),
    .offset      (offset),
    .pc          (pc),
    .busy        (busy),
    .ack         (ack),
    .cycle_count (cycle_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_step();
    step();
    exp_cnt++;
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; prog_sel = 2'd0; done_in = 1'b0;
    wpc_en = 1'b0; sel_pc_next = 1'b0; cond_true = 1'b0; offset = '0;
    step(); step();
    chk("rst_pc", pc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_cnt", cycle_count, 0);
    chk("rst_start", start, 1);

    // Straight-line run of program 1
    reset = 1'b0; req = 1'b1; prog_sel = 2'd1; wpc_en = 1'b1;
    step();
    chk("load_start", start, 1);
    chk("load_busy", busy, 1);
    req = 1'b0;
    step();
    chk("run_pc_base", pc, 128);
    chk("run_start", start, 0);
    chk("run_busy", busy, 1);
    chk("run_cnt0", cycle_count, 0);
    exp_cnt = 0;
    for (int p = 129; p <= 133; p++) begin
      run_step();
      chk("seq_pc", pc, p);
      chk("seq_cnt", cycle_count, exp_cnt);
    end
    done_in = 1'b1;
    run_step();
    chk("done_ack", ack, 1);
    chk("done_busy", busy, 0);
    chk("done_start", start, 1);
    chk("done_pc", pc, 133);
    chk("done_cnt", cycle_count, 6);
    done_in = 1'b0;
    step();
    chk("idle_ack", ack, 0);
    chk("idle_start", start, 1);
    chk("idle_cnt_hold", cycle_count, 6);

    // done_in in IDLE must not produce ack
    done_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_done_ack", ack, 0);
      chk("idle_done_busy", busy, 0);
    end
    done_in = 1'b0;

    // Program 0: branches and wrap
    prog_sel = 2'd0; req = 1'b1;
    step();
    req = 1'b0;
    step();
    chk("p0_base", pc, 0);
    exp_cnt = 0;
    for (int i = 0; i < 10; i++) run_step();
    chk("p0_pc10", pc, 10);
    sel_pc_next = 1'b1; cond_true = 1'b1; offset = -10'sd5;
    run_step();
    chk("br_neg_taken", pc, 6);
    offset = 10'sd3;
    run_step();
    chk("br_pos_taken", pc, 10);
    cond_true = 1'b0; offset = -10'sd5;
    run_step();
    chk("br_not_taken", pc, 11);
    cond_true = 1'b1; offset = -10'sd13;
    run_step();
    chk("br_to_top", pc, 1023);
    sel_pc_next = 1'b0;
    run_step();
    chk("wrap_inc", pc, 0);
    run_step(); run_step();
    chk("pc2", pc, 2);
    sel_pc_next = 1'b1; offset = -10'sd4;
    run_step();
    chk("wrap_neg", pc, 1023);
    sel_pc_next = 1'b0; wpc_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run_step();
      chk("hold_pc", pc, 1023);
      chk("hold_cnt", cycle_count, exp_cnt);
    end
    done_in = 1'b1; sel_pc_next = 1'b1; cond_true = 1'b1; wpc_en = 1'b1; offset = 10'sd5;
    run_step();
    chk("dj_pc", pc, 1023);
    chk("dj_ack", ack, 1);
    chk("dj_busy", busy, 0);
    chk("dj_cnt", cycle_count, 22);
    done_in = 1'b0; sel_pc_next = 1'b0;
    step();
    chk("dj_ack_once", ack, 0);
    chk("dj_pc_idle", pc, 1023);

    // Program 2 with req pulsed during RUN
    prog_sel = 2'd2; req = 1'b1;
    step();
    req = 1'b0;
    step();
    chk("p2_base", pc, 256);
    run_step();
    req = 1'b1;
    run_step();
    chk("rreq_pc", pc, 258);
    chk("rreq_busy", busy, 1);
    req = 1'b0;
    run_step();
    chk("rreq_no_restart", pc, 259);
    chk("rreq_start", start, 0);

    // req held through DONE with prog_sel=3 restarts at program 0 base
    req = 1'b1; prog_sel = 2'd3; done_in = 1'b1;
    run_step();
    chk("held_done_ack", ack, 1);
    done_in = 1'b0;
    step();
    chk("held_idle_start", start, 1);
    chk("held_idle_busy", busy, 0);
    step();
    chk("held_load_busy", busy, 1);
    chk("held_load_start", start, 1);
    req = 1'b0;
    step();
    chk("sel3_pc", pc, 0);
    chk("sel3_cnt_clr", cycle_count, 0);
    chk("sel3_start", start, 0);
    done_in = 1'b1;
    step();
    done_in = 1'b0;
    step();

    // Reset mid-run at pc=140
    prog_sel = 2'd1; req = 1'b1;
    step();
    req = 1'b0;
    step();
    for (int i = 0; i < 12; i++) step();
    chk("pre_rst_pc", pc, 140);
    reset = 1'b1; done_in = 1'b1;
    step();
    chk("mid_rst_pc", pc, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ack", ack, 0);
    chk("mid_rst_cnt", cycle_count, 0);
    chk("mid_rst_start", start, 1);
    reset = 1'b0; done_in = 1'b0;
    step();
    chk("post_rst_ack", ack, 0);
    chk("post_rst_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
